mlt3_encoder: RTL

Transmit-side MLT-3 line encoder. Accepts parallel words over a valid/ready handshake, serializes them LSB first, and drives a 2-bit MLT-3 line-level code. It pairs with the existing MLT-3 receiver/decoder: a `1` bit advances the level code by one (mod 4), and a `0` bit holds it. It sits between the word source and the line driver/loopback path of the interface lab.

---
 rtl/mlt3_encoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mlt3_encoder.sv
// mlt3_encoder
// Transmit-side MLT-3 line encoder. Words are accepted over a valid/ready
// handshake, serialized LSB first, and each emitted bit advances the 2-bit
// line level by one (mod 4) for a '1' or holds it for a '0'.
//
// Optional feature: define MLT3_ENCODER_PARITY_EN to append one even-parity
// bit after each word. The word then takes DATA_W+1 cycles and produces an
// even number of level increments.
//
// Ports:
//   clk    - single clock, all logic on the rising edge
//   rst    - synchronous active-high reset
//   data   - word to transmit, captured only on acceptance
//   valid  - source has a word on data
//   ready  - encoder accepts a word on this edge (pure function of state)
//   code   - MLT-3 line level: 00 top, 01 down, 10 bottom, 11 up
//   busy   - a word (or its parity bit) is being serialized
module mlt3_encoder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic [1:0]        code,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] sr, sr_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [1:0]        code_next;
`ifdef MLT3_ENCODER_PARITY_EN
    logic              par, par_next;
`endif

    // State and datapath registers. Reset wins over any handshake in the
    // same cycle and drops the line back to the decoder's reset level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            code  <= 2'b00;
`ifdef MLT3_ENCODER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            sr    <= sr_next;
            cnt   <= cnt_next;
            code  <= code_next;
`ifdef MLT3_ENCODER_PARITY_EN
            par   <= par_next;
`endif
        end
    end

    // Next-state and handshake logic. ready is decided from state/counter
    // alone; valid only chooses between reloading and returning to IDLE.
    // The reload on the final bit lets back-to-back words stream gap-free.
    always_comb begin
        state_next = state;
        sr_next    = sr;
        cnt_next   = cnt;
        code_next  = code;
        ready      = 1'b0;
`ifdef MLT3_ENCODER_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    sr_next    = data;
                    cnt_next   = '0;
                    state_next = SEND;
`ifdef MLT3_ENCODER_PARITY_EN
                    par_next   = ^data;
`endif
                end
            end
            SEND: begin
                code_next = code + {1'b0, sr[0]};
                sr_next   = sr >> 1;
                cnt_next  = cnt + CNT_W'(1);
                if (cnt == LAST_BIT) begin
                    cnt_next = '0;
`ifdef MLT3_ENCODER_PARITY_EN
                    state_next = PARITY;
`else
                    ready = 1'b1;
                    if (valid) begin
                        sr_next    = data;
                        state_next = SEND;
                    end else begin
                        state_next = IDLE;
                    end
`endif
                end
            end
`ifdef MLT3_ENCODER_PARITY_EN
            PARITY: begin
                ready     = 1'b1;
                code_next = code + {1'b0, par};
                cnt_next  = '0;
                if (valid) begin
                    sr_next    = data;
                    par_next   = ^data;
                    state_next = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
